// File: rtl/axi4_frame_writer.sv
// axi4_frame_writer: drains 64-bit pixel words from an FWFT FIFO and writes
// them to DDR as 64-beat AXI4 INCR bursts, one frame = FRAME_BYTES bytes.
// Ports:
//   clk_100Mhz, rst (sync, active high), frame_start (1-cycle SOF pulse)
//   FRAME_BASE_ADDR          frame buffer base (512-aligned byte address)
//   fifo_dout/empty/prog_empty/rd_en   FWFT FIFO read side
//   AW*/W*/B*                AXI4 write address, data and response channels
//   frame_done               pulse when the last burst of a frame is acked
//   rd_base_addr             base of the last completed frame (for reader)
//   resp_err                 sticky error flag for any non-OKAY BRESP
//   state, ADDR_OFFSET       debug: FSM state and current burst offset
// Build option: define DOUBLE_BUFFER_EN to alternate the write base between
// FRAME_BASE_ADDR and FRAME_BASE_ADDR + FRAME_BYTES on every completed frame.
module axi4_frame_writer #(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 64,
   parameter int BURST_BYTES    = 512,
   parameter int FRAME_BYTES    = 153600
) (
   input  logic                        clk_100Mhz,
   input  logic                        rst,
   input  logic                        frame_start,
   input  logic [AXI_ADDR_WIDTH-1:0]   FRAME_BASE_ADDR,
   input  logic [AXI_DATA_WIDTH-1:0]   fifo_dout,
   input  logic                        fifo_empty,
   input  logic                        fifo_prog_empty,
   output logic                        fifo_rd_en,
   output logic [AXI_ADDR_WIDTH-1:0]   AWADDR,
   output logic                        AWVALID,
   input  logic                        AWREADY,
   output logic [7:0]                  AWLEN,
   output logic [2:0]                  AWSIZE,
   output logic [1:0]                  AWBURST,
   output logic [3:0]                  AWCACHE,
   output logic [2:0]                  AWPROT,
   output logic [AXI_DATA_WIDTH-1:0]   WDATA,
   output logic [AXI_DATA_WIDTH/8-1:0] WSTRB,
   output logic                        WLAST,
   output logic                        WVALID,
   input  logic                        WREADY,
   input  logic                        BVALID,
   output logic                        BREADY,
   input  logic [1:0]                  BRESP,
   output logic                        frame_done,
   output logic [AXI_ADDR_WIDTH-1:0]   rd_base_addr,
   output logic                        resp_err,
   output logic [2:0]                  state,
   output logic [31:0]                 ADDR_OFFSET
);

   typedef enum logic [2:0] {
      WAIT_SOF   = 3'd0,
      IDLE       = 3'd1,
      ADDR_SEND  = 3'd2,
      DATA_WRITE = 3'd3,
      RESP_WAIT  = 3'd4,
      DONE       = 3'd5
   } state_t;

   localparam logic [31:0] BURST_INC = 32'(BURST_BYTES);
   localparam logic [31:0] FRAME_END = 32'(FRAME_BYTES);

   state_t                    fsm, fsm_nxt;
   logic [31:0]               offset, offset_nxt, offset_inc;
   logic [AXI_ADDR_WIDTH-1:0] awaddr_r, awaddr_nxt;
   logic [AXI_ADDR_WIDTH-1:0] rd_base_r, rd_base_nxt;
   logic [AXI_ADDR_WIDTH-1:0] base;
   logic                      awvalid_r, awvalid_nxt;
   logic                      pending, pending_nxt;
   logic                      done_r, done_nxt;
   logic                      err_r, err_nxt;
   logic [5:0]                beat, beat_nxt;
   logic                      w_hs, b_hs;

`ifdef DOUBLE_BUFFER_EN
   logic buf_sel, buf_sel_nxt;
   assign base = buf_sel ? FRAME_BASE_ADDR + AXI_ADDR_WIDTH'(FRAME_BYTES)
                         : FRAME_BASE_ADDR;
`else
   assign base = FRAME_BASE_ADDR;
`endif

   assign WVALID     = (fsm == DATA_WRITE) && !fifo_empty;
   assign WLAST      = (fsm == DATA_WRITE) && (beat == 6'd63);
   assign BREADY     = (fsm == RESP_WAIT);
   assign w_hs       = WVALID && WREADY;
   assign b_hs       = BREADY && BVALID;
   assign fifo_rd_en = w_hs;
   assign offset_inc = offset + BURST_INC;

   always_comb begin
      fsm_nxt     = fsm;
      offset_nxt  = offset;
      awaddr_nxt  = awaddr_r;
      awvalid_nxt = awvalid_r;
      rd_base_nxt = rd_base_r;
      pending_nxt = pending;
      beat_nxt    = beat;
      err_nxt     = err_r;
      done_nxt    = 1'b0;
`ifdef DOUBLE_BUFFER_EN
      buf_sel_nxt = buf_sel;
`endif
      unique case (fsm)
         WAIT_SOF, DONE: begin
            if (frame_start) begin
               offset_nxt = '0;
               fsm_nxt    = IDLE;
            end
         end
         IDLE: begin
            if (frame_start)
               offset_nxt = '0;
            if (!fifo_prog_empty) begin
               // A same-cycle frame_start restarts at offset 0 right away
               awaddr_nxt  = base + AXI_ADDR_WIDTH'(frame_start ? 32'd0 : offset);
               awvalid_nxt = 1'b1;
               fsm_nxt     = ADDR_SEND;
            end
         end
         ADDR_SEND: begin
            if (frame_start)
               pending_nxt = 1'b1;
            if (AWREADY) begin
               awvalid_nxt = 1'b0;
               beat_nxt    = '0;
               fsm_nxt     = DATA_WRITE;
            end
         end
         DATA_WRITE: begin
            if (frame_start)
               pending_nxt = 1'b1;
            if (w_hs) begin
               beat_nxt = beat + 6'd1;
               if (WLAST)
                  fsm_nxt = RESP_WAIT;
            end
         end
         RESP_WAIT: begin
            if (b_hs) begin
               if (BRESP != 2'b00)
                  err_nxt = 1'b1;
               pending_nxt = 1'b0;
               // A new frame began while this burst was in flight:
               // drop the truncated frame and restart at offset 0
               if (pending || frame_start) begin
                  offset_nxt = '0;
                  fsm_nxt    = IDLE;
               end else if (offset_inc == FRAME_END) begin
                  offset_nxt  = offset_inc;
                  done_nxt    = 1'b1;
                  rd_base_nxt = base;
`ifdef DOUBLE_BUFFER_EN
                  buf_sel_nxt = !buf_sel;
`endif
                  fsm_nxt     = DONE;
               end else begin
                  offset_nxt = offset_inc;
                  fsm_nxt    = IDLE;
               end
            end else if (frame_start) begin
               pending_nxt = 1'b1;
            end
         end
         default: fsm_nxt = WAIT_SOF;
      endcase
   end

   always_ff @(posedge clk_100Mhz) begin
      if (rst) begin
         fsm       <= WAIT_SOF;
         offset    <= '0;
         awaddr_r  <= '0;
         awvalid_r <= 1'b0;
         rd_base_r <= FRAME_BASE_ADDR;
         pending   <= 1'b0;
         beat      <= '0;
         err_r     <= 1'b0;
         done_r    <= 1'b0;
`ifdef DOUBLE_BUFFER_EN
         buf_sel   <= 1'b0;
`endif
      end else begin
         fsm       <= fsm_nxt;
         offset    <= offset_nxt;
         awaddr_r  <= awaddr_nxt;
         awvalid_r <= awvalid_nxt;
         rd_base_r <= rd_base_nxt;
         pending   <= pending_nxt;
         beat      <= beat_nxt;
         err_r     <= err_nxt;
         done_r    <= done_nxt;
`ifdef DOUBLE_BUFFER_EN
         buf_sel   <= buf_sel_nxt;
`endif
      end
   end

   assign AWADDR       = awaddr_r;
   assign AWVALID      = awvalid_r;
   assign AWLEN        = 8'd63;
   assign AWSIZE       = 3'b011;
   assign AWBURST      = 2'b01;
   assign AWCACHE      = 4'b0011;
   assign AWPROT       = 3'b000;
   assign WDATA        = fifo_dout;
   assign WSTRB        = '1;
   assign frame_done   = done_r;
   assign rd_base_addr = rd_base_r;
   assign resp_err     = err_r;
   assign state        = fsm;
   assign ADDR_OFFSET  = offset;

endmodule

// File: tb/tb_axi4_frame_writer.sv
// Testbench for axi4_frame_writer: bench-side FIFO and AXI slave, with a
// transaction-level model of frames, bursts and beats checked every cycle.
module tb_axi4_frame_writer;

   localparam int          FB   = 153600;
   localparam logic [31:0] BASE = 32'h1000_0000;
`ifdef DOUBLE_BUFFER_EN
   localparam logic [31:0] BASE2 = 32'h1002_5800;
`else
   localparam logic [31:0] BASE2 = 32'h1000_0000;
`endif

   logic        clk_100Mhz = 1'b0;
   logic        rst;
   logic        frame_start;
   logic [31:0] FRAME_BASE_ADDR;
   logic [63:0] fifo_dout;
   logic        fifo_empty, fifo_prog_empty, fifo_rd_en;
   logic [31:0] AWADDR;
   logic        AWVALID, AWREADY;
   logic [7:0]  AWLEN;
   logic [2:0]  AWSIZE;
   logic [1:0]  AWBURST;
   logic [3:0]  AWCACHE;
   logic [2:0]  AWPROT;
   logic [63:0] WDATA;
   logic [7:0]  WSTRB;
   logic        WLAST, WVALID, WREADY;
   logic        BVALID, BREADY;
   logic [1:0]  BRESP;
   logic        frame_done;
   logic [31:0] rd_base_addr;
   logic        resp_err;
   logic [2:0]  state;
   logic [31:0] ADDR_OFFSET;

   always #5 clk_100Mhz = ~clk_100Mhz;

   axi4_frame_writer dut (
      .clk_100Mhz(clk_100Mhz), .rst(rst), .frame_start(frame_start),
      .FRAME_BASE_ADDR(FRAME_BASE_ADDR), .fifo_dout(fifo_dout),
      .fifo_empty(fifo_empty), .fifo_prog_empty(fifo_prog_empty),
      .fifo_rd_en(fifo_rd_en), .AWADDR(AWADDR), .AWVALID(AWVALID),
      .AWREADY(AWREADY), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
      .AWBURST(AWBURST), .AWCACHE(AWCACHE), .AWPROT(AWPROT),
      .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID),
      .WREADY(WREADY), .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
      .frame_done(frame_done), .rd_base_addr(rd_base_addr),
      .resp_err(resp_err), .state(state), .ADDR_OFFSET(ADDR_OFFSET)
   );

   int total = 0;
   int bad   = 0;

   // model state
   bit          armed = 0, busy = 0, awv = 0, pending = 0;
   bit          done_pulse = 0, m_err = 0, exp_wv;
   int          wbeats = 0, bcnt = 0, bdelay = 2, exp_word = 0;
   logic [31:0] off = 0, base_cur = BASE, rd_base = BASE, awaddr_m = 0;

   // stimulus state
   int  prod = 0, cons = 0;
   bit  fast = 1, err_mode = 0, fs_req = 0;
   int  n_aw = 0, n_rd = 0, n_done = 0;
   logic [31:0] first_aw = 0, last_aw = 0;

   function automatic void chk(string name, logic [63:0] got,
                               logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
      end
   endfunction

   function automatic logic [63:0] word(int n);
      logic [31:0] n32;
      n32 = 32'(n);
      return {n32 * 32'h9E37_79B1, n32};
   endfunction

   task automatic cycle();
      bit fs;
      @(negedge clk_100Mhz);
      fs = fs_req;
      fs_req = 0;
      frame_start = fs;
      if (fast) begin
         while (prod - cons < 256) prod++;
      end else if (prod - cons < 200 && $urandom_range(99) < 80) begin
         prod++;
      end
      fifo_dout       = word(cons);
      fifo_empty      = (prod <= cons) || (!fast && $urandom_range(99) < 12);
      fifo_prog_empty = (prod - cons) < 64;
      AWREADY = fast ? 1'b1 : ($urandom_range(99) < 70);
      WREADY  = fast ? 1'b1 : ($urandom_range(99) < 75);
      BVALID  = busy && wbeats == 64 && bcnt >= bdelay;
      BRESP   = (BVALID && err_mode && off == 32'd2560) ? 2'b10 : 2'b00;
      #1;
      exp_wv = busy && !awv && wbeats < 64 && !fifo_empty;
      chk("AWVALID", AWVALID, awv);
      if (awv) chk("AWADDR", AWADDR, awaddr_m);
      chk("WVALID", WVALID, exp_wv);
      if (exp_wv) begin
         chk("WLAST", WLAST, wbeats == 63);
         chk("WDATA", WDATA, word(exp_word));
      end
      chk("fifo_rd_en", fifo_rd_en, exp_wv && WREADY);
      chk("BREADY", BREADY, busy && wbeats == 64);
      chk("frame_done", frame_done, done_pulse);
      chk("resp_err", resp_err, m_err);
      chk("rd_base_addr", rd_base_addr, rd_base);
      chk("ADDR_OFFSET", ADDR_OFFSET, off);
      if (fifo_rd_en) begin
         n_rd++;
         cons++;
      end
      if (frame_done) n_done++;
      if (AWVALID && AWREADY) begin
         if (n_aw == 0) first_aw = AWADDR;
         last_aw = AWADDR;
         n_aw++;
      end
      // advance the model across the coming clock edge
      done_pulse = 0;
      if (!armed) begin
         if (fs) begin
            armed = 1;
            off = 0;
         end
      end else if (!busy) begin
         if (fs) off = 0;
         if (!fifo_prog_empty) begin
            busy = 1;
            awv = 1;
            wbeats = 0;
            awaddr_m = base_cur + off;
         end
      end else begin
         if (fs) pending = 1;
         if (awv) begin
            if (AWREADY) awv = 0;
         end else if (wbeats < 64) begin
            if (exp_wv && WREADY) begin
               wbeats++;
               exp_word++;
               if (wbeats == 64) begin
                  bcnt = 0;
                  bdelay = fast ? 2 : int'($urandom_range(3));
               end
            end
         end else if (BVALID) begin
            if (BRESP != 2'b00) m_err = 1;
            busy = 0;
            if (pending) begin
               off = 0;
               pending = 0;
            end else begin
               off += 512;
               if (off == FB) begin
                  done_pulse = 1;
                  rd_base = base_cur;
                  armed = 0;
`ifdef DOUBLE_BUFFER_EN
                  base_cur = (base_cur == BASE) ? BASE + FB : BASE;
`endif
               end
            end
         end else begin
            bcnt++;
         end
      end
   endtask

   initial begin
      rst = 1;
      frame_start = 0;
      FRAME_BASE_ADDR = BASE;
      AWREADY = 0;
      WREADY = 0;
      BVALID = 0;
      BRESP = 0;
      prod = 256;
      fifo_dout = word(0);
      fifo_empty = 0;
      fifo_prog_empty = 0;
      repeat (3) @(negedge clk_100Mhz);
      #1;
      chk("rst_state", state, 0);
      chk("rst_offset", ADDR_OFFSET, 0);
      chk("rst_awaddr", AWADDR, 0);
      chk("rst_awvalid", AWVALID, 0);
      chk("rst_wvalid", WVALID, 0);
      chk("rst_bready", BREADY, 0);
      chk("rst_rd_en", fifo_rd_en, 0);
      chk("rst_done", frame_done, 0);
      chk("rst_err", resp_err, 0);
      chk("rst_rdbase", rd_base_addr, BASE);
      rst = 0;

      // no frame_start: nothing may be written
      repeat (1000) cycle();
      chk("idle_state", state, 0);
      chk("idle_aw_count", n_aw, 0);

      // full frame, no back-pressure, error response on burst 5
      err_mode = 1;
      fs_req = 1;
      for (int i = 0; i < 30000 && n_done == 0; i++) cycle();
      chk("A_done_seen", n_done, 1);
      repeat (3) cycle();
      err_mode = 0;
      chk("A_aw_count", n_aw, 300);
      chk("A_first_aw", first_aw, BASE);
      chk("A_last_aw", last_aw, 32'h1002_5600);
      chk("A_rd_count", n_rd, 19200);
      chk("A_done_count", n_done, 1);
      chk("A_state", state, 5);
      chk("A_offset", ADDR_OFFSET, FB);
      chk("A_resp_err", resp_err, 1);
      chk("A_rdbase", rd_base_addr, BASE);
      chk("AWLEN", AWLEN, 63);
      chk("AWSIZE", AWSIZE, 3);
      chk("AWBURST", AWBURST, 1);
      chk("AWCACHE", AWCACHE, 3);
      chk("AWPROT", AWPROT, 0);
      chk("WSTRB", WSTRB, 8'hFF);

      // random back-pressure, abort at beat 20 of burst 3, then full frame
      fast = 0;
      n_aw = 0;
      n_rd = 0;
      n_done = 0;
      fs_req = 1;
      for (int i = 0; i < 8000; i++) begin
         if (n_aw == 4 && busy && !awv && wbeats == 20) break;
         cycle();
      end
      chk("B_reached_beat20", wbeats, 20);
      fs_req = 1;
      for (int i = 0; i < 2000 && n_aw < 5; i++) cycle();
      chk("B_abort_aw_count", n_aw, 5);
      chk("B_restart_aw", last_aw, BASE2);
      chk("B_first_aw", first_aw, BASE2);
      chk("B_no_done", n_done, 0);
      for (int i = 0; i < 45000 && n_done == 0; i++) cycle();
      chk("B_done_seen", n_done, 1);
      repeat (3) cycle();
      chk("B_aw_count", n_aw, 304);
      chk("B_rd_count", n_rd, 19456);
      chk("B_last_aw", last_aw, BASE2 + 32'h2_5600);
      chk("B_state", state, 5);
      chk("B_rdbase", rd_base_addr, BASE2);
      chk("B_resp_err", resp_err, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
